alu_mul_sequencer: RTL and testbench
====================================

ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and ALU data width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port start  input  1  request one unsigned multiply; sampled only in IDLE.
REQ-006 Port Ra  input  32  multiplicand, captured on the accepting edge.
REQ-007 Port Rb  input  32  multiplier, captured on the accepting edge.
REQ-008 Port CoreSrcA, CoreSrcB  input  32 each  datapath ALU operands.
REQ-009 Port CoreALUControl  input  2  datapath ALU operation.
REQ-010 Port SrcA, SrcB  output  32 each  operands driven to the shared ALU.
REQ-011 Port ALUControl  output  2  operation driven to the shared ALU.
REQ-012 Port ALUResult  input  32  result from the shared ALU.
REQ-013 Port ALUFlags  input  4  ALU flags {N,Z,C,V} at bits [3:0]; C is bit 1.
REQ-014 Port busy  output  1  high while the sequencer owns the ALU; datapath stall.
REQ-015 Port done  output  1  one-cycle completion pulse.
REQ-016 Port ProductHi, ProductLo  output  32 each  64-bit product, registered.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE -> RUN on an edge with start=1: capture Ra into M, clear the HI register, load Rb into the LO register, clear the step counter.
REQ-019 start SHALL be ignored in RUN and DONE; it is neither queued nor a restart.
REQ-020 In RUN, ALU drive: SrcA=HI; SrcB=(LO[0] ? M : 0); ALUControl=2'b00 (add, carry-in 0).
REQ-021 Each RUN edge SHALL load {HI,LO} <= {ALUFlags[1], ALUResult, LO[31:1]}, a right shift of the 65-bit value, and increment the counter.
REQ-022 On the RUN edge where the counter equals WIDTH-1 (32nd step), next state SHALL be DONE.
REQ-023 The transition to DONE SHALL also load ProductHi/ProductLo from the final {HI,LO}; the product holds until the next completion or reset.
REQ-024 DONE -> IDLE unconditionally on the next edge; done=1 only in DONE.
REQ-025 busy=1 exactly in RUN: 32 cycles per operation; done occurs in the 33rd cycle after the accepting edge.
REQ-026 In IDLE and DONE, SrcA/SrcB/ALUControl SHALL combinationally equal CoreSrcA/CoreSrcB/CoreALUControl.
REQ-027 Arithmetic SHALL be unsigned 32x32->64 with no truncation; the carry comes only from ALUFlags[1].
REQ-028 Operand 0 or 0xFFFFFFFF SHALL take the same 32 cycles; there is no early termination.

Reset
REQ-029 When reset=1 on an edge, including mid-RUN, the block SHALL go to IDLE, clear M/HI/LO/counter, set ProductHi=ProductLo=0 and drive busy=0, done=0.
REQ-030 A start concurrent with reset SHALL be discarded.
REQ-031 After reset, the ALU ports SHALL be in pass-through (REQ-026).

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, RUN, DONE), the ALU opcodes (ADD=00, SUB=01, AND=10, OR=11) and the flag indices (N=3, Z=2, C=1, V=0).
REQ-033 The ALU SHALL remain external; this block contains no adder and does not instantiate the ALU.
REQ-034 No sub-module is needed; the FSM, counter and shift registers are one module.

Verification
REQ-035 The bench SHALL connect the real ALU to SrcA/SrcB/ALUControl/ALUResult/ALUFlags.
REQ-036 Ra=3, Rb=5, start pulse -> busy for 32 cycles, done in cycle 33, Product=0x00000000_0000000F.
REQ-037 Ra=Rb=0xFFFFFFFF -> Product=0xFFFFFFFE_00000001 (checks carry propagation).
REQ-038 Idle pass-through: CoreSrcA=7, CoreSrcB=2, CoreALUControl=01 -> ALUResult=5, busy=0; during RUN the ALU sees the sequencer operands and opcode 00.
REQ-039 Ra=0x10000, Rb=0x10000 with start re-pulsed at RUN cycle 5 -> one done only, Product=0x00000001_00000000.
REQ-040 Reset at RUN cycle 10 of 7*9 -> next cycle IDLE, busy=0, Product=0; a new start with 6*7 -> Product=0x2A.

Source files
------------

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared types and constants for the shift-add multiply sequencer that borrows
// the datapath ALU.
package alu_mul_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bus between the core, the shared ALU and the multiply sequencer.
// The slave side is the sequencer; the master side is the core/ALU environment.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] Ra;
    logic [WIDTH-1:0] Rb;
    logic [WIDTH-1:0] CoreSrcA;
    logic [WIDTH-1:0] CoreSrcB;
    logic [1:0]       CoreALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [1:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic [3:0]       ALUFlags;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ProductHi;
    logic [WIDTH-1:0] ProductLo;

    modport slave (
        input  start, Ra, Rb, CoreSrcA, CoreSrcB, CoreALUControl, ALUResult, ALUFlags,
        output SrcA, SrcB, ALUControl, busy, done, ProductHi, ProductLo
    );

    modport master (
        output start, Ra, Rb, CoreSrcA, CoreSrcB, CoreALUControl, ALUResult, ALUFlags,
        input  SrcA, SrcB, ALUControl, busy, done, ProductHi, ProductLo
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned 32x32->64 shift-add multiplier that time-shares the external datapath
// ALU, stalling the core via busy for 32 cycles per operation.
//
// state | meaning
// IDLE  | ALU passed through to the core; waits for start
// RUN   | one add-and-shift step per cycle using the shared ALU
// DONE  | one-cycle done pulse; product registers already updated
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_mul_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        cnt_d          = cnt_q;
        prod_hi_d      = prod_hi_q;
        prod_lo_d      = prod_lo_q;
        bus.SrcA       = bus.CoreSrcA;
        bus.SrcB       = bus.CoreSrcB;
        bus.ALUControl = bus.CoreALUControl;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    m_d     = bus.Ra;
                    hi_d    = '0;
                    lo_d    = bus.Rb;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                bus.busy       = 1'b1;
                bus.SrcA       = hi_q;
                bus.SrcB       = lo_q[0] ? m_q : '0;
                bus.ALUControl = ALU_ADD;
                // Carry out of the add becomes the new MSB of the shifted accumulator.
                {hi_d, lo_d}   = {bus.ALUFlags[FLAG_C], bus.ALUResult, lo_q[WIDTH-1:1]};
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d   = DONE;
                    prod_hi_d = hi_d;
                    prod_lo_d = lo_d;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ProductHi = prod_hi_q;
    assign bus.ProductLo = prod_lo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized self-checking bench: a behavioural ALU plus an arithmetic model of the
// multiply sequence checked against the DUT every cycle.
module tb_alu_mul_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_mul_sequencer_if #(.WIDTH(32)) bus ();

    alu_mul_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural shared ALU.
    logic [32:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (bus.ALUControl)
            2'b00:   alu_wide = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
            2'b01:   alu_wide = {1'b0, bus.SrcA} + {1'b0, ~bus.SrcB} + 33'd1;
            2'b10:   alu_wide = {1'b0, bus.SrcA & bus.SrcB};
            default: alu_wide = {1'b0, bus.SrcA | bus.SrcB};
        endcase
        bus.ALUResult   = alu_wide[31:0];
        bus.ALUFlags[3] = alu_wide[31];
        bus.ALUFlags[2] = (alu_wide[31:0] == 32'd0);
        bus.ALUFlags[1] = bus.ALUControl[1] ? 1'b0 : alu_wide[32];
        bus.ALUFlags[0] = (bus.ALUControl == 2'b00) ?
                          ((bus.SrcA[31] == bus.SrcB[31]) && (alu_wide[31] != bus.SrcA[31])) :
                          (bus.ALUControl == 2'b01) ?
                          ((bus.SrcA[31] != bus.SrcB[31]) && (alu_wide[31] != bus.SrcA[31])) : 1'b0;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Model: phase 0 idle, 1 multiplying, 2 done pulse; k = steps completed.
    int          mdl_phase = 0;
    int          mdl_k     = 0;
    logic [31:0] mdl_ra    = '0;
    logic [31:0] mdl_rb    = '0;
    logic [63:0] mdl_prod  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_edge();
        if (reset) begin
            mdl_phase = 0;
            mdl_k     = 0;
            mdl_ra    = '0;
            mdl_rb    = '0;
            mdl_prod  = '0;
        end else begin
            case (mdl_phase)
                0: if (bus.start) begin
                    mdl_phase = 1;
                    mdl_ra    = bus.Ra;
                    mdl_rb    = bus.Rb;
                    mdl_k     = 0;
                end
                1: begin
                    mdl_k++;
                    if (mdl_k == 32) begin
                        mdl_phase = 2;
                        mdl_prod  = 64'(mdl_ra) * 64'(mdl_rb);
                    end
                end
                default: mdl_phase = 0;
            endcase
        end
    endtask

    // Upper accumulator after k steps: partial product of the low k multiplier bits, scaled down by k.
    function automatic logic [31:0] exp_hi(input logic [31:0] ra, input logic [31:0] rb, input int k);
        logic [31:0] mask;
        logic [63:0] p;
        mask = (32'd1 << k) - 32'd1;
        p    = 64'(ra) * 64'(rb & mask);
        return 32'(p >> k);
    endfunction

    task automatic check_cycle();
        chk("busy", 64'(bus.busy), 64'(mdl_phase == 1));
        chk("done", 64'(bus.done), 64'(mdl_phase == 2));
        chk("product", {bus.ProductHi, bus.ProductLo}, mdl_prod);
        if (mdl_phase == 1) begin
            chk("run_srca", 64'(bus.SrcA), 64'(exp_hi(mdl_ra, mdl_rb, mdl_k)));
            chk("run_srcb", 64'(bus.SrcB), 64'(mdl_rb[mdl_k] ? mdl_ra : 32'd0));
            chk("run_op", 64'(bus.ALUControl), 64'(2'b00));
        end else begin
            chk("pass_srca", 64'(bus.SrcA), 64'(bus.CoreSrcA));
            chk("pass_srcb", 64'(bus.SrcB), 64'(bus.CoreSrcB));
            chk("pass_op", 64'(bus.ALUControl), 64'(bus.CoreALUControl));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    // Start one multiply; cycles are numbered from 1 after the accepting edge.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int restart_at, input int reset_at,
                           output int busy_n, output int done_n, output int done_at);
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        bus.Ra    = a;
        bus.Rb    = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                done_at = i;
            end
            bus.CoreSrcA       = $urandom;
            bus.CoreSrcB       = $urandom;
            bus.CoreALUControl = 2'($urandom);
            bus.Ra             = $urandom;
            bus.Rb             = $urandom;
            bus.start          = (i == restart_at);
            if (i == reset_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                bus.start = 1'b0;
                break;
            end
            step();
        end
        bus.start = 1'b0;
    endtask

    int busy_n, done_n, done_at;

    initial begin
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.Ra             = '0;
        bus.Rb             = '0;
        bus.CoreSrcA       = '0;
        bus.CoreSrcB       = '0;
        bus.CoreALUControl = 2'b00;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_product", {bus.ProductHi, bus.ProductLo}, 64'd0);

        bus.CoreSrcA       = 32'd7;
        bus.CoreSrcB       = 32'd2;
        bus.CoreALUControl = 2'b01;
        #1;
        chk("idle_alu_result", 64'(bus.ALUResult), 64'd5);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        step();

        run_mul(32'd3, 32'd5, -1, -1, busy_n, done_n, done_at);
        chk("3x5_busy_cycles", 64'(busy_n), 64'd32);
        chk("3x5_done_cycle", 64'(done_at), 64'd33);
        chk("3x5_product", {bus.ProductHi, bus.ProductLo}, 64'h0000_0000_0000_000F);

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, busy_n, done_n, done_at);
        chk("max_product", {bus.ProductHi, bus.ProductLo}, 64'hFFFF_FFFE_0000_0001);
        chk("max_busy_cycles", 64'(busy_n), 64'd32);

        run_mul(32'd0, 32'd0, -1, -1, busy_n, done_n, done_at);
        chk("zero_busy_cycles", 64'(busy_n), 64'd32);
        chk("zero_product", {bus.ProductHi, bus.ProductLo}, 64'd0);

        run_mul(32'h0001_0000, 32'h0001_0000, 5, -1, busy_n, done_n, done_at);
        chk("restart_done_count", 64'(done_n), 64'd1);
        chk("restart_product", {bus.ProductHi, bus.ProductLo}, 64'h0000_0001_0000_0000);

        run_mul(32'd7, 32'd9, -1, 10, busy_n, done_n, done_at);
        chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
        chk("midrun_reset_product", {bus.ProductHi, bus.ProductLo}, 64'd0);
        chk("midrun_reset_no_done", 64'(done_n), 64'd0);
        step();

        run_mul(32'd6, 32'd7, -1, -1, busy_n, done_n, done_at);
        chk("6x7_product", {bus.ProductHi, bus.ProductLo}, 64'h0000_0000_0000_002A);

        reset     = 1'b1;
        bus.start = 1'b1;
        bus.Ra    = 32'd9;
        bus.Rb    = 32'd9;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        step();
        chk("start_with_reset_busy", 64'(bus.busy), 64'd0);

        for (int n = 0; n < 20; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (n % 4 == 0) a = 32'hFFFF_FFFF;
            run_mul(a, b, (n % 3 == 0) ? int'($urandom_range(1, 31)) : -1, -1,
                    busy_n, done_n, done_at);
            chk("rand_done_count", 64'(done_n), 64'd1);
            chk("rand_product", {bus.ProductHi, bus.ProductLo}, 64'(a) * 64'(b));
            repeat ($urandom_range(0, 3)) begin
                bus.CoreSrcA       = $urandom;
                bus.CoreSrcB       = $urandom;
                bus.CoreALUControl = 2'($urandom);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
